// File: rtl/intc_bridge_if.sv
// Data-bus slave port of the interrupt controller: CPU address/store signals in,
// combinational read data and window hit out.
interface intc_bridge_if;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] rdata;
    logic        hit;

    modport master (
        output m_data_addr, m_data_wdata, m_data_byteen,
        input  rdata, hit
    );

    modport slave (
        input  m_data_addr, m_data_wdata, m_data_byteen,
        output rdata, hit
    );
endinterface

// File: rtl/intc_bridge.sv
// Memory-mapped interrupt controller: pending/mask/mode/status registers, one registered
// request per source. Define INTC_SYNC_EN to put a 2-flop synchronizer on src_in.
module intc_bridge #(
    parameter int unsigned N_SRC = 6,
    parameter logic [31:0] BASE  = 32'h0000_7F20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_in,
    intc_bridge_if.slave     bus,
    output logic [N_SRC-1:0] hw_int,
    output logic             irq
);
    localparam int unsigned IDX_W    = 5;
    localparam logic [1:0]  REG_PEND = 2'd0;
    localparam logic [1:0]  REG_MASK = 2'd1;
    localparam logic [1:0]  REG_MODE = 2'd2;
    localparam logic [1:0]  REG_STAT = 2'd3;

    logic [N_SRC-1:0] pend, mask, mode;
    logic [N_SRC-1:0] s, s_q;
    logic [N_SRC-1:0] set, clr, active;
    logic [N_SRC-1:0] lane_n, wdata_n;
    logic [31:0]      lane_mask;
    logic [1:0]       sel;
    logic             wr_en;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rdata_c;
    logic             unused_bits;

`ifdef INTC_SYNC_EN
    logic [N_SRC-1:0] sync1, sync2;

    // Two-flop synchronizer for asynchronous sources
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= src_in;
            sync2 <= sync1;
        end
    end
    assign s = sync2;
`else
    assign s = src_in;
`endif

    assign bus.hit   = (bus.m_data_addr[31:4] == BASE[31:4]);
    assign sel       = bus.m_data_addr[3:2];
    assign wr_en     = bus.hit && (|bus.m_data_byteen);
    assign lane_mask = {{8{bus.m_data_byteen[3]}}, {8{bus.m_data_byteen[2]}},
                        {8{bus.m_data_byteen[1]}}, {8{bus.m_data_byteen[0]}}};
    assign lane_n    = lane_mask[N_SRC-1:0];
    assign wdata_n   = bus.m_data_wdata[N_SRC-1:0];

    assign set    = (mode & s & ~s_q) | (~mode & s);
    assign clr    = (wr_en && sel == REG_PEND) ? (wdata_n & lane_n) : '0;
    assign active = pend & mask;

    // Lowest-numbered active source wins the status index
    always_comb begin
        idx = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (active[i]) idx = IDX_W'(i);
        end
    end

    always_comb begin
        rdata_c = '0;
        if (bus.hit) begin
            case (sel)
                REG_PEND: rdata_c = 32'(pend);
                REG_MASK: rdata_c = 32'(mask);
                REG_MODE: rdata_c = 32'(mode);
                REG_STAT: rdata_c = {|active, 26'd0, idx};
                default:  rdata_c = '0;
            endcase
        end
    end
    assign bus.rdata = rdata_c;

    // Set takes priority over a same-edge W1C; outputs use pre-update pend/mask
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend   <= '0;
            mask   <= '0;
            mode   <= '0;
            s_q    <= '0;
            hw_int <= '0;
            irq    <= 1'b0;
        end else begin
            s_q    <= s;
            pend   <= (pend & ~clr) | set;
            hw_int <= active;
            irq    <= |active;
            if (wr_en && sel == REG_MASK) mask <= (mask & ~lane_n) | (wdata_n & lane_n);
            if (wr_en && sel == REG_MODE) mode <= (mode & ~lane_n) | (wdata_n & lane_n);
        end
    end

    assign unused_bits = ^{bus.m_data_addr[1:0], bus.m_data_wdata, lane_mask};
endmodule

// File: tb/tb_intc_bridge.sv
// Directed bench for intc_bridge: expectations queued on a scoreboard as stimulus is
// driven, popped and checked when the corresponding output is observed.
module tb_intc_bridge;
`ifdef INTC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam logic [31:0] A_PEND = 32'h0000_7F20;
    localparam logic [31:0] A_MASK = 32'h0000_7F24;
    localparam logic [31:0] A_MODE = 32'h0000_7F28;
    localparam logic [31:0] A_STAT = 32'h0000_7F2C;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] src_in;
    logic [5:0] hw_int;
    logic       irq;
    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;

    intc_bridge_if bus ();

    intc_bridge #(.N_SRC(6), .BASE(32'h0000_7F20)) dut (
        .clk    (clk),
        .reset  (reset),
        .src_in (src_in),
        .bus    (bus.slave),
        .hw_int (hw_int),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.m_data_addr   = a;
        bus.m_data_byteen = 4'b0000;
        #1;
        d = bus.rdata;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        push(tag, exp);
        rd(a, d);
        check(d);
    endtask

    task automatic chk_out(input string tag, input logic [5:0] exp_hw, input logic exp_irq);
        push({tag, "_hw"}, 32'(exp_hw));
        check(32'(hw_int));
        push({tag, "_irq"}, 32'(exp_irq));
        check(32'(irq));
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.m_data_addr   = a;
        bus.m_data_wdata  = d;
        bus.m_data_byteen = be;
        step(1);
        bus.m_data_byteen = 4'b0000;
    endtask

    initial begin
        reset             = 1'b0;
        src_in            = '0;
        bus.m_data_addr   = '0;
        bus.m_data_wdata  = '0;
        bus.m_data_byteen = '0;
        step(3);
        reset = 1'b1;
        step(1);

        // Reset state and register map boundaries
        chk_rd("rst_pend", A_PEND, 32'h0);
        chk_rd("rst_mask", A_MASK, 32'h0);
        chk_rd("rst_mode", A_MODE, 32'h0);
        chk_rd("rst_stat", A_STAT, 32'h0);
        chk_out("rst", 6'h00, 1'b0);
        wr(A_MASK, 32'hFFFF_FFFF, 4'b1111);
        chk_rd("mask_upper_bits", A_MASK, 32'h0000_003F);
        wr(A_STAT, 32'hFFFF_FFFF, 4'b1111);
        chk_rd("stat_write_ignored", A_STAT, 32'h0);
        chk_rd("miss_rdata", 32'h0000_7F34, 32'h0);
        push("miss_hit", 32'h0);
        check(32'(bus.hit));
        wr(A_MODE, 32'h0000_003F, 4'b0001);
        chk_rd("mode_set", A_MODE, 32'h0000_003F);

        // Edge-mode one-cycle pulse on source 2
        src_in[2] = 1'b1;
        step(1);
        src_in[2] = 1'b0;
        step(LAT);
        chk_rd("pulse_pend", A_PEND, 32'h0000_0004);
        chk_out("pulse_early", 6'h00, 1'b0);
        step(1);
        chk_out("pulse", 6'h04, 1'b1);
        chk_rd("pulse_stat", A_STAT, 32'h8000_0002);

        // W1C on the wrong lane, then the right lane
        wr(A_PEND, 32'h0000_0004, 4'b0010);
        chk_rd("w1c_wrong_lane", A_PEND, 32'h0000_0004);
        wr(A_PEND, 32'h0000_0004, 4'b0001);
        chk_rd("w1c_pend", A_PEND, 32'h0);
        chk_out("w1c_hold", 6'h04, 1'b1);
        step(1);
        chk_out("w1c_drop", 6'h00, 1'b0);

        // Level mode: held source cannot be cleared
        wr(A_MODE, 32'h0, 4'b1111);
        src_in[0] = 1'b1;
        step(LAT + 2);
        chk_rd("lvl_pend", A_PEND, 32'h0000_0001);
        chk_out("lvl", 6'h01, 1'b1);
        wr(A_PEND, 32'h0000_0001, 4'b0001);
        chk_rd("lvl_noclr", A_PEND, 32'h0000_0001);
        src_in[0] = 1'b0;
        step(LAT + 2);
        wr(A_PEND, 32'h0000_0001, 4'b0001);
        chk_rd("lvl_clr", A_PEND, 32'h0);

        // Masked edge event stays pending, surfaces when unmasked
        wr(A_MASK, 32'h0, 4'b1111);
        wr(A_MODE, 32'h0000_003F, 4'b1111);
        src_in[5] = 1'b1;
        step(LAT + 2);
        src_in[5] = 1'b0;
        chk_rd("masked_pend", A_PEND, 32'h0000_0020);
        chk_out("masked", 6'h00, 1'b0);
        wr(A_MASK, 32'h0000_0020, 4'b0001);
        chk_out("unmask_edge", 6'h00, 1'b0);
        step(1);
        chk_out("unmask", 6'h20, 1'b1);
        chk_rd("unmask_stat", A_STAT, 32'h8000_0005);

        // Simultaneous edges, then asynchronous reset mid-cycle
        wr(A_MASK, 32'h0000_003F, 4'b0001);
        wr(A_PEND, 32'h0000_0020, 4'b0001);
        src_in[1] = 1'b1;
        src_in[4] = 1'b1;
        step(LAT + 2);
        src_in = '0;
        chk_rd("dual_pend", A_PEND, 32'h0000_0012);
        chk_out("dual", 6'h12, 1'b1);
        chk_rd("dual_stat", A_STAT, 32'h8000_0001);
        #2;
        reset = 1'b0;
        #1;
        chk_out("async_rst", 6'h00, 1'b0);
        chk_rd("async_rst_pend", A_PEND, 32'h0);
        step(2);
        reset = 1'b1;
        step(1);
        chk_rd("post_rst_mask", A_MASK, 32'h0);

        push("sb_drained", 32'h0);
        check(32'(sb.size() - 1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/intc_bridge.md
# intc_bridge

Memory-mapped interrupt controller between the external interrupt sources (timers, external interrupt line) and the CPU's `HWInt` inputs. It latches source events into a pending register, applies a software mask, and drives one registered interrupt line per source. It also clears pending bits when the CPU stores to the acknowledge address. It is a data-bus slave decoded alongside data memory and the timers, occupying a 16-byte window at `BASE` (0x7F20–0x7F2F).

## Interface
- `N_SRC`, default 6: number of interrupt sources; maps to `HWInt[7:2]`.
- `BASE`, default 32'h0000_7F20: word-aligned base of the 16-byte register window.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `src_in`, in, `N_SRC`: raw interrupt source levels.
- `m_data_addr`, in, 32: CPU data-bus byte address.
- `m_data_wdata`, in, 32: store data.
- `m_data_byteen`, in, 4: byte-lane write enables; all-zero means no write.
- `rdata`, out, 32: combinational read data for `m_data_addr`.
- `hit`, out, 1: combinational; `m_data_addr[31:4] == BASE[31:4]`.
- `hw_int`, out, `N_SRC`: registered per-source interrupt request.
- `irq`, out, 1: registered OR of `hw_int`.

## Operation
- Register map is decoded on `m_data_addr[3:2]`:
  - Offset 0x0 `PEND`: read returns pending bits. Write is write-1-to-clear, applied per enabled byte lane.
  - Offset 0x4 `MASK`: read/write, byte-lane masked. Bit i = 1 enables source i.
  - Offset 0x8 `MODE`: read/write, byte-lane masked. Bit i = 1 selects rising-edge mode; 0 selects level mode.
  - Offset 0xC `STATUS`: read-only; writes are ignored.
    - bit31 = `|(PEND & MASK)`.
    - bits[4:0] = lowest index i with `PEND[i] & MASK[i]`, or 0 if none.
- Bits at or above `N_SRC` in every register read as 0 and ignore writes.
- `rdata` = 0 when `hit` = 0.
- Writes take effect only when `hit` is true and `|m_data_byteen` is true.
- Source sample `s`: `src_in` passed through the synchronizer (see Configuration). `s_q` is `s` delayed one cycle.
- Pending set term: `set[i]` = `MODE[i] ? (s[i] & ~s_q[i]) : s[i]`.
- Pending update each edge: `PEND` <= `(PEND & ~clr) | set`.
  - Set wins over a simultaneous clear.
  - A level-mode source held high therefore cannot be cleared.
- Output update each edge: `hw_int` <= `PEND & MASK` and `irq` <= `|(PEND & MASK)`. Both use the pre-update register values.
- A `MASK` write affects `hw_int` one edge after the write edge.
- An edge event on a masked source still sets `PEND`. It raises `hw_int` as soon as it is unmasked.
- Reset values (async, while `reset` = 0): `PEND`=0, `MASK`=0, `MODE`=0, `hw_int`=0, `irq`=0, and all synchronizer and `s_q` flops = 0.
- Reset asserted mid-operation discards all pending events immediately.
- After reset release, a source already high is seen as a rising edge, because `s_q` = 0.

## Timing
- Register reads are zero-latency (combinational on address).
- Writes commit at the rising edge where address and `byteen` are valid.
- Source to `hw_int` latency with synchronizer, for `src_in` high sampled at edge t:
  - edge t+1: `s` high.
  - edge t+2: `PEND` set.
  - edge t+3: `hw_int` high.
- Without synchronizer: `PEND` sets at edge t and `hw_int` rises at edge t+1.
- Ack: a W1C to `PEND` at edge t clears `PEND` at t and drops `hw_int` at t+1, provided the source does not re-set.
- An edge-mode pulse must last at least 1 cycle to be captured. Pulses shorter than a clock period may be lost when the synchronizer is enabled.

## Configuration
- Macro `INTC_SYNC_EN`.
- Defined: `s` is a 2-flop synchronizer on `src_in`, reset to 0.
- Undefined: `s` = `src_in` directly. For synchronous sources only; latency reduces by 2 cycles.
- All register and bus behaviour is identical either way.

## Test plan
- Reset, then read all 4 offsets -> every read 0; `hw_int`=0, `irq`=0.
- `MASK`=0x3F, `MODE`=0x3F, pulse `src_in[2]` for 1 cycle -> with sync, `hw_int`=6'b000100 exactly 3 edges after the sample edge; `STATUS`=0x8000_0002.
- With `PEND`=0x04, store 0x04 to 0x7F20 with `byteen`=4'b0001 -> `PEND`=0 at the write edge, `hw_int`=0 one edge later. Store with `byteen`=4'b0010 -> no clear.
- Level mode (`MODE`=0), hold `src_in[0]`=1, W1C 0x01 -> `PEND[0]` stays 1. Drop source, W1C again -> `PEND[0]`=0.
- `MASK`=0, edge on `src_in[5]` -> `PEND`=0x20, `hw_int`=0. Write `MASK`=0x20 -> `hw_int[5]`=1 one edge later; `STATUS`=0x8000_0005.
- Edges on sources 1 and 4 in the same cycle, then assert `reset`=0 asynchronously mid-cycle -> `PEND`, `hw_int` and `irq` drop to 0 immediately without waiting for a clock edge.
